// File: rtl/fifo_rd_prefetch_if.sv
// Handshake bundle between the FIFO read port, the prefetch stage and the
// downstream consumer. The prefetch stage uses the slave view; whatever
// models the FIFO and the consumer uses the master view.
interface fifo_rd_prefetch_if #(
    parameter int WIDTH = 16
);
    logic             fifo_empty;
    logic             fifo_pop;
    logic             fifo_valid;
    logic [WIDTH-1:0] fifo_rdata;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;

    modport slave (
        input  fifo_empty, fifo_valid, fifo_rdata, m_ready,
        output fifo_pop, m_valid, m_data
    );

    modport master (
        output fifo_empty, fifo_valid, fifo_rdata, m_ready,
        input  fifo_pop, m_valid, m_data
    );
endinterface

// File: rtl/fifo_rd_prefetch.sv
// Read-side prefetch stage for the split-SRAM FIFO. Pops are issued
// speculatively whenever the skid buffer can absorb every outstanding
// return, so the fixed pop-to-data latency of the FIFO is hidden and the
// consumer sees a valid/ready stream at one word per cycle.
module fifo_rd_prefetch #(
    parameter  int WIDTH = 16,
    parameter  int LAT   = 2,
    parameter  int BUF   = 4,
    localparam int CW    = $clog2(BUF + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fifo_rd_prefetch_if.slave     bus,
    output logic [CW-1:0]         occ,
    output logic                  err
);

    localparam int             IW       = (BUF > 1) ? $clog2(BUF) : 1;
    localparam logic [CW-1:0]  BUF_C    = CW'(BUF);
    localparam logic [IW-1:0]  LAST_IDX = IW'(BUF - 1);

    // A buffer shallower than LAT+1 cannot cover the in-flight words at full rate.
    if (BUF < LAT + 1) begin : g_buf_check
        $error("fifo_rd_prefetch: BUF (%0d) must be >= LAT+1 (%0d)", BUF, LAT + 1);
    end

    logic [CW-1:0]    occ_q, occ_d;
    logic [CW-1:0]    inflight_q, inflight_d;
    logic [IW-1:0]    wr_idx_q, wr_idx_d;
    logic [IW-1:0]    rd_idx_q, rd_idx_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] mem_q [BUF];

    logic             deq;
    logic             pop;
    logic             wr_en;
    logic             full_hit;
    logic [CW+1:0]    avail;
    logic [CW+1:0]    used;

    // Handshake decode, pop decision and next-state for indices and counters.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        occ_d      = occ_q;
        inflight_d = inflight_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        err_d      = err_q;

        deq = (occ_q != '0) && bus.m_ready;

        // space = BUF - occ - inflight + deq, compared rather than subtracted
        // so it can never go negative even after a protocol error.
        avail = (CW+2)'(BUF) + (CW+2)'(deq);
        used  = (CW+2)'(occ_q) + (CW+2)'(inflight_q);
        pop   = rst_n && !bus.fifo_empty && (avail > used);

        // A return that finds the buffer full with no drain is dropped and flagged.
        full_hit = bus.fifo_valid && (occ_q == BUF_C) && !deq;
        wr_en    = bus.fifo_valid && !full_hit;

        if (pop && !bus.fifo_valid) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!pop && bus.fifo_valid && (inflight_q != '0)) begin
            inflight_d = inflight_q - 1'b1;
        end

        occ_d = occ_q + CW'(wr_en) - CW'(deq);

        if (wr_en) begin
            wr_idx_d = (wr_idx_q == LAST_IDX) ? '0 : wr_idx_q + 1'b1;
        end
        if (deq) begin
            rd_idx_d = (rd_idx_q == LAST_IDX) ? '0 : rd_idx_q + 1'b1;
        end

        if ((bus.fifo_valid && (inflight_q == '0)) || full_hit) begin
            err_d = 1'b1;
        end
    end

    // Control state: counters, circular indices and the sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q      <= '0;
            inflight_q <= '0;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            err_q      <= err_d;
        end
    end

    // Skid storage: returned words land at the write index.
    always_ff @(posedge clk) begin
        // NOTE: data storage has no reset; m_data is masked while occ is zero.
        if (wr_en) begin
            mem_q[wr_idx_q] <= bus.fifo_rdata;
        end
    end

    assign bus.fifo_pop = pop;
    assign bus.m_valid  = (occ_q != '0);
    assign bus.m_data   = (occ_q != '0) ? mem_q[rd_idx_q] : '0;
    assign occ          = occ_q;
    assign err          = err_q;

endmodule

// File: tb/tb_fifo_rd_prefetch.sv
// Self-checking bench for fifo_rd_prefetch. A queue-based FIFO model feeds
// the DUT with a fixed return latency; a queue-based reference of the skid
// buffer predicts every output each cycle.
module tb_fifo_rd_prefetch;

    localparam int               WIDTH    = 16;
    localparam int               LAT      = 2;
    localparam int               BUF      = 4;
    localparam int               CW       = $clog2(BUF + 1);
    localparam logic [WIDTH-1:0] INJ_WORD = 16'hDEAD;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] occ;
    logic          err;

    fifo_rd_prefetch_if #(.WIDTH(WIDTH)) bus ();

    fifo_rd_prefetch #(.WIDTH(WIDTH), .LAT(LAT), .BUF(BUF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .occ   (occ),
        .err   (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               due;
        logic [WIDTH-1:0] d;
    } ret_t;

    logic [WIDTH-1:0] fq[$];   // words still inside the FIFO
    logic [WIDTH-1:0] sq[$];   // reference skid-buffer contents
    ret_t             ret[$];  // popped words on their way back
    int               inflight_m;
    bit               err_m;
    int               cyc;
    logic [WIDTH-1:0] next_word;
    logic [WIDTH-1:0] next_out;
    bit               inject;

    int n_checks;
    int n_errors;
    int pops_seen;
    int valid_seen;
    int max_occ;
    int run;
    int max_run;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic load(input int n);
        repeat (n) begin
            fq.push_back(next_word);
            next_word++;
        end
    endtask

    // One clock cycle: called at a falling edge, returns at the next one.
    task automatic cycle(input bit rdy);
        bit               emp;
        bit               v;
        logic [WIDTH-1:0] d;
        int               occ0;
        bit               deq_m;
        int               space;
        bit               pop_m;
        logic [WIDTH-1:0] w;

        emp = (fq.size() == 0);
        v   = 1'b0;
        d   = '0;
        if (ret.size() > 0 && ret[0].due == cyc) begin
            v = 1'b1;
            d = ret[0].d;
            void'(ret.pop_front());
        end
        if (inject) begin
            v = 1'b1;
            d = INJ_WORD;
        end
        bus.m_ready    = rdy;
        bus.fifo_empty = emp;
        bus.fifo_valid = v;
        bus.fifo_rdata = d;
        #1;

        occ0  = sq.size();
        deq_m = (occ0 != 0) && rdy;
        space = BUF - occ0 - inflight_m + int'(deq_m);
        pop_m = !emp && (space > 0);

        check("m_valid", bus.m_valid, occ0 != 0);
        check("m_data", bus.m_data, (occ0 != 0) ? sq[0] : '0);
        check("occ", occ, occ0);
        check("fifo_pop", bus.fifo_pop, pop_m);
        check("err", err, err_m);
        if (deq_m && sq[0] != INJ_WORD) begin
            check("order", bus.m_data, next_out);
            next_out++;
        end

        if (bus.fifo_pop) pops_seen++;
        if (bus.m_valid) begin
            valid_seen++;
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        if (int'(occ) > max_occ) max_occ = int'(occ);

        if (deq_m) void'(sq.pop_front());
        if (v) begin
            if (inflight_m == 0) err_m = 1'b1;
            if (occ0 == BUF && !deq_m) err_m = 1'b1;
            else sq.push_back(d);
        end
        inflight_m = inflight_m + int'(pop_m) - int'(v);
        if (inflight_m < 0) inflight_m = 0;
        if (pop_m) begin
            w = fq.pop_front();
            ret.push_back('{due: cyc + LAT, d: w});
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300 && (fq.size() + ret.size() + sq.size()) != 0; i++) cycle(1'b1);
        check(tag, fq.size() + ret.size() + sq.size(), 0);
    endtask

    task automatic clear_stats();
        pops_seen  = 0;
        valid_seen = 0;
        max_occ    = 0;
        run        = 0;
        max_run    = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] first;
        int               pops0;

        n_checks   = 0;
        n_errors   = 0;
        inflight_m = 0;
        err_m      = 1'b0;
        cyc        = 1;
        inject     = 1'b0;
        next_word  = 16'h0100;
        next_out   = 16'h0100;
        clear_stats();

        // Reset with three words waiting: nothing may be popped while in reset.
        load(3);
        bus.fifo_empty = 1'b0;
        bus.fifo_valid = 1'b0;
        bus.fifo_rdata = '0;
        bus.m_ready    = 1'b1;
        #1;
        check("rst_pop", bus.fifo_pop, 0);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_occ", occ, 0);
        check("rst_err", err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Three words A,B,C with the consumer always ready.
        for (int i = 0; i < 8; i++) cycle(1'b1);
        check("p1_pops", pops_seen, 3);
        check("p1_valid_cycles", valid_seen, 3);
        check("p1_occ_peak", max_occ, 1);

        // Sustained streaming of 100 words.
        clear_stats();
        load(100);
        drain("p2_drain");
        check("p2_run", max_run, 100);
        check("p2_err", err, 0);

        // Consumer stalled: exactly BUF pops, then the pop request stops.
        clear_stats();
        load(10);
        first = fq[0];
        for (int i = 0; i < 10; i++) cycle(1'b0);
        check("p3_pops", pops_seen, BUF);
        check("p3_occ", occ, BUF);
        check("p3_pop_idle", bus.fifo_pop, 0);
        check("p3_head", bus.m_data, first);

        // Single ready pulse from full: one deq and one refill pop.
        pops0 = pops_seen;
        cycle(1'b1);
        check("p4_one_pop", pops_seen - pops0, 1);
        for (int i = 0; i < LAT - 1; i++) cycle(1'b0);
        check("p4_occ_dip", occ, BUF - 1);
        cycle(1'b0);
        check("p4_occ_back", occ, BUF);

        // Random consumer stalls with the FIFO running dry and refilling.
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 4) == 0) load($urandom_range(1, 3));
            cycle($urandom_range(0, 3) != 0);
        end
        drain("p5_drain");
        check("p5_no_loss", next_out, next_word);
        check("p5_idle_valid", bus.m_valid, 0);
        check("p5_idle_occ", occ, 0);
        check("p5_err", err, 0);

        // Spurious return with nothing outstanding sets a sticky error.
        inject = 1'b1;
        cycle(1'b0);
        inject = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b0);
        check("p6_err_sticky", err, 1);
        load(20);
        for (int i = 0; i < 8; i++) cycle(1'b1);
        check("p6_err_held", err, 1);

        // Asynchronous reset mid-stream, away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_occ", occ, 0);
        check("arst_m_valid", bus.m_valid, 0);
        check("arst_err", err, 0);
        check("arst_pop", bus.fifo_pop, 0);
        fq.delete();
        ret.delete();
        sq.delete();
        inflight_m = 0;
        err_m      = 1'b0;
        next_out   = next_word;
        @(negedge clk);
        rst_n = 1'b1;

        // Recovery after reset.
        load(5);
        drain("p7_drain");
        check("p7_no_loss", next_out, next_word);
        check("p7_err", err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
